// File: rtl/vx_ex_commit_arbiter.sv
// Execute-stage commit arbiter: per-unit commit FIFOs merged onto one commit channel
// by a round-robin or fixed-priority grant, with flush and a saturating stall counter.
module vx_ex_commit_arbiter #(
    parameter int NUM_UNITS  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 2,
    parameter int ARB_MODE   = 0,
    parameter int CNT_WIDTH  = 32,
    localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic [NUM_UNITS-1:0]            in_valid,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] in_data,
    output logic [NUM_UNITS-1:0]            in_ready,
    output logic                            out_valid,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [UW-1:0]                   out_unit,
    input  logic                            out_ready,
    output logic [CNT_WIDTH-1:0]            stall_count
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [DATA_WIDTH-1:0] mem [NUM_UNITS][FIFO_DEPTH];
    logic [PW-1:0]         wptr [NUM_UNITS];
    logic [PW-1:0]         rptr [NUM_UNITS];
    logic [CW-1:0]         cnt  [NUM_UNITS];

    logic                 running;
    logic [UW-1:0]        rr_ptr;
    logic                 hold;
    logic [UW-1:0]        held;

    logic [NUM_UNITS-1:0] nonempty;
    logic [NUM_UNITS-1:0] push;
    logic [NUM_UNITS-1:0] pop_u;
    logic [UW-1:0]        base;
    logic [UW-1:0]        idx;
    logic [UW-1:0]        search;
    logic                 found;
    logic [UW-1:0]        grant;
    logic                 pop;

    // running gates in_ready off while reset is asserted, since counts alone read as "not full"
    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            nonempty[i] = (cnt[i] != '0);
            in_ready[i] = running && !flush && (cnt[i] != CW'(FIFO_DEPTH));
            push[i]     = in_valid[i] && in_ready[i];
        end
    end

    // Grant: a stalled head keeps its grant; otherwise search from the base index
    always_comb begin
        base   = (ARB_MODE == 0) ? rr_ptr : '0;
        idx    = base;
        found  = 1'b0;
        search = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (!found && nonempty[idx]) begin
                found  = 1'b1;
                search = idx;
            end
            idx = (idx == UW'(NUM_UNITS - 1)) ? '0 : idx + 1'b1;
        end
        grant     = hold ? held : search;
        out_valid = |nonempty;
        out_unit  = out_valid ? grant : '0;
        out_data  = out_valid ? mem[grant][rptr[grant]] : '0;
        pop       = out_valid && out_ready && !flush;
        for (int i = 0; i < NUM_UNITS; i++) begin
            pop_u[i] = pop && (grant == UW'(i));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (push[i]) mem[i][wptr[i]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (push[i])  wptr[i] <= ptr_inc(wptr[i]);
                if (pop_u[i]) rptr[i] <= ptr_inc(rptr[i]);
                case ({push[i], pop_u[i]})
                    2'b10:   cnt[i] <= cnt[i] + 1'b1;
                    2'b01:   cnt[i] <= cnt[i] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            running     <= 1'b0;
            rr_ptr      <= '0;
            hold        <= 1'b0;
            held        <= '0;
            stall_count <= '0;
        end else begin
            running <= 1'b1;
            if (out_valid && !out_ready) stall_count <= sat_inc(stall_count);
            if (flush) begin
                rr_ptr <= '0;
                hold   <= 1'b0;
            end else begin
                hold <= out_valid && !out_ready;
                held <= grant;
                if (pop && ARB_MODE == 0)
                    rr_ptr <= (grant == UW'(NUM_UNITS - 1)) ? '0 : grant + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vx_ex_commit_arbiter.sv
// Bench for vx_ex_commit_arbiter: a round-robin and a fixed-priority instance share the
// same stimulus and are each checked against a queue-based reference model.
module tb_vx_ex_commit_arbiter;
    localparam int NU = 4;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              out_ready;
    logic [NU-1:0]     in_valid;
    logic [NU*DW-1:0]  in_data;

    logic [NU-1:0]     rdy_a, rdy_b;
    logic              ov_a, ov_b;
    logic [DW-1:0]     od_a, od_b;
    logic [1:0]        ou_a, ou_b;
    logic [7:0]        sc_a;
    logic [3:0]        sc_b;

    logic [NU-1:0]     rdy_o [2];
    logic              ov_o  [2];
    logic [DW-1:0]     od_o  [2];
    logic [1:0]        ou_o  [2];
    logic [31:0]       sc_o  [2];

    always #5 clk = ~clk;

    vx_ex_commit_arbiter #(.NUM_UNITS(NU), .DATA_WIDTH(DW), .FIFO_DEPTH(2), .ARB_MODE(0), .CNT_WIDTH(8)) dut_a (
        .clk(clk), .reset(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_a), .out_valid(ov_a), .out_data(od_a), .out_unit(ou_a),
        .out_ready(out_ready), .stall_count(sc_a));

    vx_ex_commit_arbiter #(.NUM_UNITS(NU), .DATA_WIDTH(DW), .FIFO_DEPTH(3), .ARB_MODE(1), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .reset(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_b), .out_valid(ov_b), .out_data(od_b), .out_unit(ou_b),
        .out_ready(out_ready), .stall_count(sc_b));

    always_comb begin
        rdy_o[0] = rdy_a;  rdy_o[1] = rdy_b;
        ov_o[0]  = ov_a;   ov_o[1]  = ov_b;
        od_o[0]  = od_a;   od_o[1]  = od_b;
        ou_o[0]  = ou_a;   ou_o[1]  = ou_b;
        sc_o[0]  = 32'(sc_a);
        sc_o[1]  = 32'(sc_b);
    end

    // Reference model: one queue per (instance, unit) plus arbitration bookkeeping
    int          depth [2];
    int          mode  [2];
    longint      cmax  [2];
    logic [DW-1:0] q [2*NU][$];
    int          rr      [2];
    bit          hold    [2];
    int          held    [2];
    longint      stall   [2];
    bit          running [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int m = 0; m < 2; m++) begin
            for (int u = 0; u < NU; u++) q[m*NU+u].delete();
            rr[m] = 0; hold[m] = 0; held[m] = 0; stall[m] = 0; running[m] = 0;
        end
    endtask

    task automatic predict(input int m, output bit ov, output int g, output logic [NU-1:0] rdy);
        ov = 0; g = 0; rdy = '0;
        for (int u = 0; u < NU; u++) begin
            if (q[m*NU+u].size() != 0) ov = 1;
            rdy[u] = running[m] && rst_n && !flush && (q[m*NU+u].size() < depth[m]);
        end
        if (hold[m]) g = held[m];
        else if (ov) begin
            for (int k = 0; k < NU; k++) begin
                int u;
                u = (mode[m] == 0) ? (rr[m] + k) % NU : k;
                if (q[m*NU+u].size() != 0) begin
                    g = u;
                    break;
                end
            end
        end
    endtask

    // Called at a falling edge: drive, check just after, advance the model, wait for next falling edge
    task automatic cycle(input logic [NU-1:0] iv, input logic ordy, input logic fl, input logic rn);
        bit            ov;
        int            g;
        logic [NU-1:0] rdy;
        logic [DW-1:0] exp_d;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        rst_n     = rn;
        for (int u = 0; u < NU; u++) in_data[u*DW +: DW] = DW'($urandom);
        if (!rn) reset_model();
        #1;
        for (int m = 0; m < 2; m++) begin
            predict(m, ov, g, rdy);
            exp_d = ov ? q[m*NU+g][0] : '0;
            check(m == 0 ? "a.in_ready"    : "b.in_ready",    64'(rdy_o[m]), 64'(rdy));
            check(m == 0 ? "a.out_valid"   : "b.out_valid",   64'(ov_o[m]),  64'(ov));
            check(m == 0 ? "a.out_data"    : "b.out_data",    64'(od_o[m]),  64'(exp_d));
            check(m == 0 ? "a.out_unit"    : "b.out_unit",    64'(ou_o[m]),  ov ? 64'(g) : 64'd0);
            check(m == 0 ? "a.stall_count" : "b.stall_count", 64'(sc_o[m]),  64'(stall[m]));
            if (rn) begin
                running[m] = 1;
                if (ov && !ordy) stall[m] = (stall[m] == cmax[m]) ? cmax[m] : stall[m] + 1;
                if (fl) begin
                    for (int u = 0; u < NU; u++) q[m*NU+u].delete();
                    rr[m] = 0;
                    hold[m] = 0;
                end else begin
                    if (ov && ordy) begin
                        void'(q[m*NU+g].pop_front());
                        if (mode[m] == 0) rr[m] = (g + 1) % NU;
                    end
                    hold[m] = ov && !ordy;
                    held[m] = g;
                    for (int u = 0; u < NU; u++)
                        if (iv[u] && rdy[u]) q[m*NU+u].push_back(in_data[u*DW +: DW]);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        depth[0] = 2; mode[0] = 0; cmax[0] = 255;
        depth[1] = 3; mode[1] = 1; cmax[1] = 15;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; in_valid = '0; in_data = '0;
        reset_model();
        @(negedge clk);

        // reset held with all units requesting, then release
        repeat (3) cycle(4'hF, 1'b1, 1'b0, 1'b0);
        cycle(4'hF, 1'b1, 1'b0, 1'b1);
        check("a.ready_after_reset", 64'(rdy_a), 64'hF);

        // round-robin streaming
        repeat (30) cycle(4'hF, 1'b1, 1'b0, 1'b1);
        repeat (6) cycle(4'h0, 1'b1, 1'b0, 1'b1);

        // back-pressure on unit 1, then 20 stall cycles for counter saturation
        repeat (3) cycle(4'h2, 1'b0, 1'b0, 1'b1);
        repeat (20) cycle(4'h0, 1'b0, 1'b0, 1'b1);
        check("b.stall_sat", 64'(sc_b), 64'd15);
        repeat (5) cycle(4'h0, 1'b1, 1'b0, 1'b1);

        // fixed priority with units 0 and 2 loaded
        repeat (3) cycle(4'h5, 1'b0, 1'b0, 1'b1);
        repeat (8) cycle(4'h0, 1'b1, 1'b0, 1'b1);

        // flush with everything buffered and out_ready high
        repeat (3) cycle(4'hF, 1'b0, 1'b0, 1'b1);
        cycle(4'hF, 1'b1, 1'b1, 1'b1);
        check("a.empty_after_flush", 64'(ov_a), 64'd0);
        repeat (2) cycle(4'h0, 1'b1, 1'b0, 1'b1);

        // single unit streaming through several pointer wraps
        repeat (10) cycle(4'h8, 1'b1, 1'b0, 1'b1);

        // randomized traffic with occasional flush and mid-run reset
        repeat (3000) begin
            cycle(4'($urandom), ($urandom % 4) != 0, ($urandom % 64) == 0, ($urandom % 500) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
